// File: rtl/mem_access.sv
`default_nettype none
// mem_access: memory-stage load/store unit with one outstanding bus transaction,
// store lane steering on issue and load extraction/extension on completion.
module mem_access #(
  parameter int XLEN        = 64,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  input  logic                req_load_i,
  input  logic                req_store_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [63:0]         req_addr_i,
  input  logic [XLEN-1:0]     req_wdata_i,
  input  logic                hold_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                done_o,
  output logic                fault_o,
  output logic [XLEN-1:0]     rdata_o,
  output logic                dreq_valid_o,
  output logic [63:0]         dreq_addr_o,
  output logic [1:0]          dreq_size_o,
  output logic [XLEN/8-1:0]   dreq_strobe_o,
  output logic [XLEN-1:0]     dreq_data_o,
  input  logic                dresp_data_ok_i,
  input  logic [XLEN-1:0]     dresp_data_i
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              drop_q;
  logic              drop_d;
  logic              load_q;
  logic              unsigned_q;
  logic [1:0]        size_q;
  logic [OW-1:0]     off_q;
  logic              dreq_valid_q;
  logic [63:0]       dreq_addr_q;
  logic [NB-1:0]     strobe_q;
  logic [XLEN-1:0]   wdata_q;
  logic              done_q;
  logic              fault_q;
  logic [XLEN-1:0]   rdata_q;

  logic              w_accept;
  logic [OW-1:0]     w_off;
  logic [NB-1:0]     w_mask;
  logic [2:0]        w_amask;
  logic              w_misalign;
  logic              w_bad_size;
  logic              w_fault;
  logic [NB-1:0]     w_strobe;
  logic [XLEN-1:0]   w_wdata_sh;
  logic [63:0]       w_resp_sh;
  logic [63:0]       w_ext;
  logic [XLEN-1:0]   w_rdata;

  assign w_accept = (state_q == S_IDLE) && req_valid_i && (req_load_i || req_store_i) && !flush_i;
  assign w_off    = req_addr_i[OW-1:0];

  always_comb begin
    w_mask  = '1;
    w_amask = 3'd7;
    case (req_size_i)
      2'd0: begin w_mask = NB'(1);  w_amask = 3'd0; end
      2'd1: begin w_mask = NB'(3);  w_amask = 3'd1; end
      2'd2: begin w_mask = NB'(15); w_amask = 3'd3; end
      default: begin w_mask = '1;   w_amask = 3'd7; end
    endcase
  end

  assign w_misalign = (ALIGN_CHECK != 0) && ((req_addr_i[2:0] & w_amask) != 3'd0);
  assign w_bad_size = (XLEN == 32) && (req_size_i == 2'd3);
  // Load and store together is an illegal encoding; report it as a fault too.
  assign w_fault    = w_misalign || w_bad_size || (req_load_i && req_store_i);

  assign w_strobe   = req_store_i ? (w_mask << w_off) : '0;
  assign w_wdata_sh = req_wdata_i << {w_off, 3'b000};

  always_comb begin
    w_resp_sh = 64'(dresp_data_i >> {off_q, 3'b000});
    w_ext     = w_resp_sh;
    case (size_q)
      2'd0: w_ext = unsigned_q ? {56'd0, w_resp_sh[7:0]}  : {{56{w_resp_sh[7]}},  w_resp_sh[7:0]};
      2'd1: w_ext = unsigned_q ? {48'd0, w_resp_sh[15:0]} : {{48{w_resp_sh[15]}}, w_resp_sh[15:0]};
      2'd2: w_ext = unsigned_q ? {32'd0, w_resp_sh[31:0]} : {{32{w_resp_sh[31]}}, w_resp_sh[31:0]};
      default: w_ext = w_resp_sh;
    endcase
  end

  assign w_rdata = load_q ? w_ext[XLEN-1:0] : '0;
  assign drop_d  = drop_q || flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      drop_q       <= 1'b0;
      load_q       <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= 2'd0;
      off_q        <= '0;
      dreq_valid_q <= 1'b0;
      dreq_addr_q  <= '0;
      strobe_q     <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            load_q     <= req_load_i;
            unsigned_q <= req_unsigned_i;
            size_q     <= req_size_i;
            off_q      <= w_off;
            drop_q     <= 1'b0;
            if (w_fault) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q      <= S_BUSY;
              dreq_valid_q <= 1'b1;
              dreq_addr_q  <= req_addr_i;
              strobe_q     <= w_strobe;
              wdata_q      <= w_wdata_sh;
            end
          end
        end
        S_BUSY: begin
          // The bus cannot abort, so a flush only marks the result to be dropped.
          if (dresp_data_ok_i) begin
            dreq_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            if (drop_d) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b0;
              rdata_q <= w_rdata;
            end
          end else begin
            drop_q <= drop_d;
          end
        end
        S_DONE: begin
          if (flush_i || !hold_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o       = w_accept || (state_q == S_BUSY);
  assign done_o        = done_q;
  assign fault_o       = fault_q;
  assign rdata_o       = rdata_q;
  assign dreq_valid_o  = dreq_valid_q;
  assign dreq_addr_o   = dreq_addr_q;
  assign dreq_size_o   = size_q;
  assign dreq_strobe_o = strobe_q;
  assign dreq_data_o   = wdata_q;

endmodule
`default_nettype wire
